fht_adc_loader: RTL
===================

FHT_ADC_LOADER -- requirements
Module: fht_adc_loader

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 16, ADC sample width (signed, two's complement).
REQ-002 SHALL have parameter D_BIT, default 22, FHT RAM data width; D_BIT > ADC_WIDTH.
REQ-003 SHALL have parameter A_BIT, default 8, bank address width; BANK_SIZE = 2**A_BIT; frame = 4*BANK_SIZE samples.
REQ-004 SHALL have port iCLK, input, 1, single clock, all logic on rising edge.
REQ-005 SHALL have port iRESET, input, 1, asynchronous reset, active-high.
REQ-006 SHALL have port iVALID, input, 1, sample present on iADC_DATA.
REQ-007 SHALL have port iADC_DATA, input, ADC_WIDTH, signed ADC sample.
REQ-008 SHALL have port iBIT_REV, input, 1, address mode for the frame: 0 normal, 1 bit-reversed row address.
REQ-009 SHALL have port iRDY, input, 1, oRDY of the downstream fht_top.
REQ-010 SHALL have port oREADY, output, 1, loader accepts a sample this cycle.
REQ-011 SHALL have port oDATA, output, D_BIT, fixed-point sample to fht_top iDATA_0..3.
REQ-012 SHALL have port oADDR_WR, output, A_BIT, row address to fht_top iADDR_WR_0..3.
REQ-013 SHALL have port oWE, output, 4, one-hot bank write enable to fht_top iWE.
REQ-014 SHALL have port oSTART, output, 1, one-cycle start pulse to fht_top iSTART.
REQ-015 SHALL have port oBUSY, output, 1, high from the first accepted sample of a frame until the frame completes.
REQ-016 SHALL have port oDONE, output, 1, one-cycle pulse when the FHT of the loaded frame completes.

Function
REQ-017 SHALL implement states IDLE, LOAD, START, WAIT.
REQ-018 SHALL define accept as iVALID & oREADY; oREADY = 1 in IDLE and LOAD, 0 in START and WAIT.
REQ-019 SHALL keep a sample counter k of A_BIT+2 bits, zeroed in IDLE and incremented per accept.
REQ-020 SHALL sample iBIT_REV on the first accept of a frame and hold it for the whole frame; changes mid-frame SHALL be ignored.
REQ-021 SHALL register each accepted sample and drive it on the next cycle: oDATA = {iADC_DATA, (D_BIT-ADC_WIDTH) zeros}, oWE = one-hot at bit k[1:0], oADDR_WR = k[A_BIT+1:2], or its bit reversal when the latched mode is 1.
REQ-022 SHALL drive oWE = 4'b0000 in every cycle without a write; oDATA and oADDR_WR SHALL hold their last value.
REQ-023 SHALL support one accept per cycle, with no bubbles, and gaps of any length on iVALID.
REQ-024 SHALL move IDLE->LOAD on the first accept, and LOAD->START on the accept with k = 4*BANK_SIZE-1.
REQ-025 SHALL assert oSTART for exactly the one START cycle, which is the cycle after the last write cycle, then go START->WAIT.
REQ-026 SHALL register iRDY and, in WAIT, detect completion as iRDY=1 with the registered iRDY=0 (rising edge). A level-high iRDY held over from a previous frame SHALL NOT complete the frame.
REQ-027 SHALL, on completion, pulse oDONE for one cycle, deassert oBUSY in the same cycle, and return to IDLE; oREADY SHALL go high the following cycle.
REQ-028 SHALL ignore iVALID while in START or WAIT, with no overwrite of the RAM.
REQ-029 SHALL drive oBUSY = 1 in LOAD, START and WAIT, and 0 in IDLE.

Reset
REQ-030 SHALL, on iRESET=1 at any time including mid-frame, immediately force state IDLE, k=0, latched mode 0, registered iRDY 0.
REQ-031 SHALL drive these reset output values: oWE=0, oSTART=0, oDONE=0, oBUSY=0, oDATA=0, oADDR_WR=0; oREADY SHALL be 0 while iRESET=1 and 1 from the first cycle after release.
REQ-032 SHALL, after a mid-frame reset, start the next frame at k=0; no partial-frame oSTART SHALL be issued.

Verification
REQ-033 Normal frame, A_BIT=8: 1024 back-to-back samples, value = index, iBIT_REV=0 -> sample 5 gives oWE=0010, oADDR_WR=1, oDATA=5<<6; sample 1023 gives oWE=1000, oADDR_WR=255; oSTART pulses in the next cycle.
REQ-034 Bit-reverse: iBIT_REV=1 on the first sample, toggled at sample 300 -> sample 4 writes oADDR_WR=128 and sample 8 writes 64; all rows use reversed addressing.
REQ-035 Sign and width: sample -1 (16'hFFFF) -> oDATA=22'h3FFFC0; sample 16'h8000 -> oDATA=22'h200000.
REQ-036 Handshake: iRDY held 1 through START, dropped 3 cycles later, raised 10 cycles later -> oDONE exactly once, at the rising edge; iVALID pulses during WAIT produce no oWE.
REQ-037 Reset mid-frame: iRESET asserted after 500 samples -> outputs at reset values immediately; a subsequent full frame writes the first sample to oWE=0001, oADDR_WR=0, and exactly one oSTART is issued.
REQ-038 Gapped input: iVALID random at 30% duty -> 1024 writes, each row/bank exactly once, and oSTART only after the 1024th write.

Source files
------------

// File: rtl/fht_adc_loader.sv
// fht_adc_loader: packs a frame of 4*2**A_BIT signed ADC samples into the four
// FHT RAM banks, kicks the transform, and reports completion.
module fht_adc_loader #(
  parameter int ADC_WIDTH = 16,
  parameter int D_BIT     = 22,
  parameter int A_BIT     = 8
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iVALID,
  input  logic [ADC_WIDTH-1:0] iADC_DATA,
  input  logic                 iBIT_REV,
  input  logic                 iRDY,
  output logic                 oREADY,
  output logic [D_BIT-1:0]     oDATA,
  output logic [A_BIT-1:0]     oADDR_WR,
  output logic [3:0]           oWE,
  output logic                 oSTART,
  output logic                 oBUSY,
  output logic                 oDONE
);

  localparam int unsigned K_W   = A_BIT + 2;
  localparam int unsigned PAD_W = D_BIT - ADC_WIDTH;
  localparam logic [K_W-1:0] K_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               mode_q, mode_d;
  logic               rdy_q, rdy_d;
  logic               ready_q, ready_d;
  logic [D_BIT-1:0]   data_q, data_d;
  logic [A_BIT-1:0]   addr_q, addr_d;
  logic [3:0]         we_q, we_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic               mode_eff;
  logic [A_BIT-1:0]   row;
  logic [A_BIT-1:0]   row_rev;

  // Next-state, write-port and handshake logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mode_d  = mode_q;
    rdy_d   = iRDY;
    data_d  = data_q;
    addr_d  = addr_q;
    we_d    = 4'b0000;
    start_d = 1'b0;
    done_d  = 1'b0;

    accept   = iVALID & ready_q;
    // The first sample of a frame uses the live mode input; later ones the latched copy.
    mode_eff = (state_q == S_IDLE) ? iBIT_REV : mode_q;
    row      = k_q[K_W-1:2];
    for (int b = 0; b < A_BIT; b++) begin
      row_rev[b] = row[A_BIT-1-b];
    end

    if (accept) begin
      data_d = {iADC_DATA, PAD_W'(0)};
      we_d   = 4'b0001 << k_q[1:0];
      addr_d = mode_eff ? row_rev : row;
      k_d    = k_q + K_W'(1);
      mode_d = mode_eff;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (accept && (k_q == K_LAST)) state_d = S_START;
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Only a fresh rising edge of iRDY ends the frame.
        if (iRDY && !rdy_q) begin
          done_d  = 1'b1;
          k_d     = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ready reopens one cycle after the done pulse.
    ready_d = ((state_d == S_IDLE) || (state_d == S_LOAD)) && !done_d;
    busy_d  = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      mode_q  <= 1'b0;
      rdy_q   <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= 4'b0000;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      rdy_q   <= rdy_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oREADY   = ready_q;
  assign oDATA    = data_q;
  assign oADDR_WR = addr_q;
  assign oWE      = we_q;
  assign oSTART   = start_q;
  assign oBUSY    = busy_q;
  assign oDONE    = done_q;

endmodule
